// File: rtl/spart_drv_pkg.sv
// Shared definitions for the SPART echo driver: bus addresses, controller
// states, baud divisor computation and the optional uppercase transform.
package spart_drv_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT_LO = 3'd0,
    ST_INIT_HI = 3'd1,
    ST_IDLE    = 3'd2,
    ST_RD      = 3'd3,
    ST_WR      = 3'd4,
    ST_TURN    = 3'd5
  } drv_state_e;

  // DIV = clk / (16 * baud) - 1, truncated to the 16-bit divisor register pair
  function automatic logic [15:0] baud_divisor(input logic [1:0]  cfg,
                                               input int unsigned clk_hz,
                                               input int unsigned baud0,
                                               input int unsigned baud1,
                                               input int unsigned baud2,
                                               input int unsigned baud3);
    int unsigned baud;
    int unsigned div;
    case (cfg)
      2'b00:   baud = baud0;
      2'b01:   baud = baud1;
      2'b10:   baud = baud2;
      2'b11:   baud = baud3;
      default: baud = baud3;
    endcase
    div = (clk_hz / (32'd16 * baud)) - 32'd1;
    return div[15:0];
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    logic [7:0] r;
    if ((c >= 8'h61) && (c <= 8'h7A)) begin
      r = c - 8'h20;
    end else begin
      r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// Synchronous FIFO with combinational head read; push on full and pop on
// empty are ignored.
module spart_drv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign level_o   = count_q;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spart_driver_fifo.sv
// SPART bus master: programs the baud divisor from the switches, buffers
// received characters in a FIFO and echoes them back, one access per cycle.
module spart_driver_fifo
  import spart_drv_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 32'd50000000,
  parameter int unsigned BAUD_0      = 32'd4800,
  parameter int unsigned BAUD_1      = 32'd9600,
  parameter int unsigned BAUD_2      = 32'd19200,
  parameter int unsigned BAUD_3      = 32'd38400,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          UPPERCASE   = 0,
  parameter int          DROP_W      = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [1:0]                    i_br_cfg,
  input  logic                          i_rda,
  input  logic                          i_tbr,
  output logic                          o_iocs,
  output logic                          o_iorw,
  output logic [1:0]                    o_ioaddr,
  inout  wire  [7:0]                    io_databus,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [DROP_W-1:0]             o_drop_cnt,
  output logic                          o_busy
);

  drv_state_e        state_q, state_d;
  logic [1:0]        cfg_meta_q, cfg_sync_q;
  logic [1:0]        settle_q;
  logic [1:0]        prog_cfg_q, prog_cfg_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              hi_pend_q, hi_pend_d;
  logic              iocs_q, iocs_d;
  logic              iorw_q, iorw_d;
  logic [1:0]        ioaddr_q, ioaddr_d;
  logic [7:0]        dout_q, dout_d;
  logic              busy_q, busy_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              push_s, pop_s, full_s, empty_s;
  logic [7:0]        head_s, tx_byte_s;
  logic [15:0]       div_sync_s, div_prog_s;

  assign div_sync_s = baud_divisor(cfg_sync_q, CLK_FREQ_HZ, BAUD_0, BAUD_1, BAUD_2, BAUD_3);
  assign div_prog_s = baud_divisor(prog_cfg_q, CLK_FREQ_HZ, BAUD_0, BAUD_1, BAUD_2, BAUD_3);
  assign tx_byte_s  = (UPPERCASE != 0) ? to_upper(head_s) : head_s;

  // A read always happens so SPART clears rda; a full FIFO just loses the byte
  assign push_s = (state_q == ST_RD) && !full_s;
  assign pop_s  = (state_q == ST_WR);

  spart_drv_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (io_databus),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (o_fifo_level)
  );

  // Saturating drop counter
  always_comb begin
    drop_d = drop_q;
    if ((state_q == ST_RD) && full_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Next state, then bus outputs decoded from the state being entered
  always_comb begin
    state_d     = state_q;
    prog_cfg_d  = prog_cfg_q;
    cfg_valid_d = cfg_valid_q;
    hi_pend_d   = hi_pend_q;
    busy_d      = busy_q;
    iocs_d      = 1'b0;
    iorw_d      = 1'b1;
    ioaddr_d    = ADDR_BUF;
    dout_d      = 8'h00;

    case (state_q)
      ST_INIT_LO, ST_INIT_HI, ST_RD, ST_WR: state_d = ST_TURN;
      ST_TURN: begin
        if (!settle_q[1]) begin
          state_d = ST_TURN;
        end else if (hi_pend_q) begin
          state_d = ST_INIT_HI;
        end else if (!cfg_valid_q) begin
          state_d = ST_INIT_LO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cfg_sync_q != prog_cfg_q) begin
          state_d = ST_INIT_LO;
        end else if (i_rda) begin
          state_d = ST_RD;
        end else if (!empty_s && i_tbr) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_TURN;
    endcase

    case (state_d)
      ST_INIT_LO: begin
        iocs_d      = 1'b1;
        iorw_d      = 1'b0;
        ioaddr_d    = ADDR_DBL;
        dout_d      = div_sync_s[7:0];
        prog_cfg_d  = cfg_sync_q;
        cfg_valid_d = 1'b1;
        hi_pend_d   = 1'b1;
        busy_d      = 1'b1;
      end
      ST_INIT_HI: begin
        iocs_d    = 1'b1;
        iorw_d    = 1'b0;
        ioaddr_d  = ADDR_DBH;
        dout_d    = div_prog_s[15:8];
        hi_pend_d = 1'b0;
      end
      ST_RD: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = ADDR_BUF;
      end
      ST_WR: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_BUF;
        dout_d   = tx_byte_s;
      end
      ST_IDLE: busy_d = 1'b0;
      default: busy_d = busy_q;
    endcase
  end

  // Synchroniser, settle delay, controller state and registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_meta_q  <= 2'b00;
      cfg_sync_q  <= 2'b00;
      settle_q    <= 2'b00;
      state_q     <= ST_TURN;
      prog_cfg_q  <= 2'b00;
      cfg_valid_q <= 1'b0;
      hi_pend_q   <= 1'b0;
      iocs_q      <= 1'b0;
      iorw_q      <= 1'b1;
      ioaddr_q    <= ADDR_BUF;
      dout_q      <= 8'h00;
      busy_q      <= 1'b1;
      drop_q      <= '0;
    end else begin
      cfg_meta_q  <= i_br_cfg;
      cfg_sync_q  <= cfg_meta_q;
      settle_q    <= {settle_q[0], 1'b1};
      state_q     <= state_d;
      prog_cfg_q  <= prog_cfg_d;
      cfg_valid_q <= cfg_valid_d;
      hi_pend_q   <= hi_pend_d;
      iocs_q      <= iocs_d;
      iorw_q      <= iorw_d;
      ioaddr_q    <= ioaddr_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign o_iocs     = iocs_q;
  assign o_iorw     = iorw_q;
  assign o_ioaddr   = ioaddr_q;
  assign o_drop_cnt = drop_q;
  assign o_busy     = busy_q;
  assign io_databus = (iocs_q && !iorw_q) ? dout_q : 8'hzz;

endmodule

// File: tb/tb_spart_driver_fifo.sv
// Bench for spart_driver_fifo: a small SPART model answers reads, every bus
// access is logged, and echoes are compared against a queue-based model.
module tb_spart_driver_fifo;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       rda, tbr;
  wire  [7:0] databus;
  wire        iocs, iorw, busy;
  wire  [1:0] ioaddr;
  wire  [3:0] level;
  wire  [7:0] drop;

  logic [7:0] bus_rx;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];
  acc_t       log_q[$];
  bit         pend_pop, prev_cs, busy_seen, found;
  int         checks, failures, b2b_err, stat_err, max_level;
  logic [7:0] ovf [9];

  always #5 clk = ~clk;

  assign databus = (iocs && iorw) ? bus_rx : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (databus[g]);
  end

  spart_driver_fifo #(.UPPERCASE(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_br_cfg(br_cfg), .i_rda(rda), .i_tbr(tbr),
    .o_iocs(iocs), .o_iorw(iorw), .o_ioaddr(ioaddr), .io_databus(databus),
    .o_fifo_level(level), .o_drop_cnt(drop), .o_busy(busy)
  );

  function automatic logic [7:0] ref_upper(input logic [7:0] b);
    return (b inside {[8'h61:8'h7A]}) ? (b - 8'd32) : b;
  endfunction

  function automatic acc_t log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 'x;
  endfunction

  function automatic void collect_writes();
    wr_q.delete();
    foreach (log_q[i]) if (!log_q[i].rw && log_q[i].addr == 2'b00) wr_q.push_back(log_q[i].data);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_rx();
    rda    = (rx_q.size() > 0);
    bus_rx = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    refresh_rx();
  endtask

  // One clock: SPART retires the previous read, then the current access is logged
  task automatic cycle();
    @(negedge clk);
    if (pend_pop) begin
      pend_pop = 1'b0;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      refresh_rx();
    end
    if (iocs) begin
      log_q.push_back('{rw: iorw, addr: ioaddr, data: (iorw ? bus_rx : databus)});
      if (prev_cs) b2b_err++;
      if (ioaddr == 2'b01) stat_err++;
      if (iorw && ioaddr == 2'b00) pend_pop = 1'b1;
    end
    prev_cs = iocs;
    if (busy) busy_seen = 1'b1;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_echo(input string tag);
    collect_writes();
    check({tag, "_count"}, wr_q.size(), exp_q.size());
    foreach (exp_q[i]) check(tag, (i < wr_q.size()) ? {24'h0, wr_q[i]} : 'x, {24'h0, exp_q[i]});
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; b2b_err = 0; stat_err = 0; max_level = 0;
    pend_pop = 0; prev_cs = 0; busy_seen = 0;
    rst_n = 1'b1; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; bus_rx = 8'h00;
    #3 rst_n = 1'b0;
    #2;
    check("rst_iocs", iocs, 1'b0);
    check("rst_iorw", iorw, 1'b1);
    check("rst_addr", ioaddr, 2'b00);
    check("rst_bus_z", databus, 8'hFF);
    check("rst_level", level, 4'd0);
    check("rst_drop", drop, 8'd0);
    check("rst_busy", busy, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Divisor for 9600 baud is 324 = 0x0144
    run(20);
    check("init_count", log_q.size(), 2);
    check("init_lo", log_at(0), {1'b0, 2'b10, 8'h44});
    check("init_hi", log_at(1), {1'b0, 2'b11, 8'h01});
    check("init_busy", busy, 1'b0);

    log_q.delete(); max_level = 0; tbr = 1'b1;
    send(8'h61);
    run(15);
    check("up_rd", log_at(0), {1'b1, 2'b00, 8'h61});
    check("up_wr", log_at(1), {1'b0, 2'b00, 8'h41});
    check("up_count", log_q.size(), 2);
    check("up_maxlvl", max_level, 1);
    check("up_level", level, 4'd0);
    log_q.delete();
    send(8'h5B);
    run(15);
    check("nonalpha_wr", log_at(1), {1'b0, 2'b00, 8'h5B});

    // Overflow: tbr low, nine bytes into an eight-deep buffer
    tbr = 1'b0; log_q.delete();
    for (int i = 0; i < 9; i++) begin
      ovf[i] = 8'($urandom_range(32'h40, 32'h7F));
      send(ovf[i]);
      if (i < 8) exp_q.push_back(ref_upper(ovf[i]));
    end
    run(60);
    check("ovf_level", level, 4'd8);
    check("ovf_drop", drop, 8'd1);
    check("ovf_reads", log_q.size(), 9);
    tbr = 1'b1; log_q.delete();
    run(60);
    check_echo("ovf_echo");
    check("ovf_drained", level, 4'd0);

    // Reprogram to 38400 baud (divisor 80) with two bytes buffered
    tbr = 1'b0;
    send(8'h70); send(8'h7A);
    exp_q.push_back(8'h50); exp_q.push_back(8'h5A);
    run(20);
    check("rp_level", level, 4'd2);
    log_q.delete(); busy_seen = 0;
    br_cfg = 2'b11;
    run(20);
    check("rp_count", log_q.size(), 2);
    check("rp_lo", log_at(0), {1'b0, 2'b10, 8'h50});
    check("rp_hi", log_at(1), {1'b0, 2'b11, 8'h00});
    check("rp_busy_seen", busy_seen, 1'b1);
    check("rp_busy_low", busy, 1'b0);
    check("rp_level_kept", level, 4'd2);
    tbr = 1'b1; log_q.delete();
    run(20);
    check_echo("rp_echo");

    // rda and tbr together with a non-empty FIFO: read wins
    tbr = 1'b0;
    send(8'h31);
    run(15);
    check("pri_level", level, 4'd1);
    log_q.delete();
    tbr = 1'b1;
    send(8'h32);
    run(25);
    check("pri_first_rd", log_at(0), {1'b1, 2'b00, 8'h32});
    check("pri_wr1", log_at(1), {1'b0, 2'b00, 8'h31});
    check("pri_wr2", log_at(2), {1'b0, 2'b00, 8'h32});

    // Randomised echo rounds
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [7:0] b;
      n = $urandom_range(1, 5);
      log_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(32'h40, 32'h7F));
        send(b);
        exp_q.push_back(ref_upper(b));
      end
      run(n * 8 + 10);
      check_echo("rand_echo");
      check("rand_level", level, 4'd0);
    end
    check("drop_hold", drop, 8'd1);

    // Reset in the middle of a WR access
    tbr = 1'b0;
    send(8'h77);
    run(15);
    tbr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (iocs && !iorw) found = 1'b1;
    end
    check("wr_found", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_iocs", iocs, 1'b0);
    check("mid_bus_z", databus, 8'hFF);
    check("mid_level", level, 4'd0);
    check("mid_drop", drop, 8'd0);
    check("mid_busy", busy, 1'b1);
    log_q.delete(); prev_cs = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(20);
    check("reinit_count", log_q.size(), 2);
    check("reinit_lo", log_at(0), {1'b0, 2'b10, 8'h50});
    check("reinit_hi", log_at(1), {1'b0, 2'b11, 8'h00});
    check("reinit_busy", busy, 1'b0);

    check("no_back_to_back", b2b_err, 0);
    check("no_status_access", stat_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_driver_fifo.md
Name: spart_driver_fifo

Overview:
Parametrised next-generation SPART bus master that replaces the fixed echo driver. It programs the SPART baud divisor from br_cfg and re-programs it whenever br_cfg changes. Received characters are read into an internal FIFO and echoed back when the transmitter is ready, with an optional lowercase-to-uppercase transform. It sits between the board switches and the SPART register interface, and exposes drop and occupancy status for debug LEDs.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency used for divisor computation
BAUD_0 / BAUD_1 / BAUD_2 / BAUD_3, 4800 / 9600 / 19200 / 38400, baud rate selected by br_cfg 00/01/10/11
FIFO_DEPTH, 8, echo buffer entries; power of two, minimum 2
UPPERCASE, 0, 1 = convert 'a'..'z' (0x61..0x7A) to uppercase by subtracting 0x20 before transmit
DROP_W, 8, width of the saturating drop counter

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_br_cfg  input  2  baud select from switches; asynchronous
i_rda  input  1  SPART receive data available
i_tbr  input  1  SPART transmit buffer ready
o_iocs  output  1  bus chip select, active high
o_iorw  output  1  1 = read, 0 = write
o_ioaddr  output  2  00 = TX/RX buffer, 01 = status, 10 = divisor low, 11 = divisor high
io_databus  inout  8  driven only when o_iocs=1 and o_iorw=0; high-Z otherwise
o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
o_drop_cnt  output  DROP_W  count of received characters lost to a full FIFO; saturating
o_busy  output  1  high while divisor programming is in progress

Behaviour:
- Reset is asynchronous and active-low. It applies to all flops.
- Reset values: o_iocs=0, o_iorw=1, o_ioaddr=00, io_databus=Z, o_fifo_level=0, o_drop_cnt=0, o_busy=1.
- br_cfg handling:
  - i_br_cfg passes through a 2-flop synchroniser.
  - The synchronised value is compared against the latched programmed value.
  - A mismatch requests reprogramming.
- Divisor per setting: DIV = CLK_FREQ_HZ/(16*BAUD) - 1, using integer division and a 16-bit result.
- Default divisors at 50 MHz: 00 = 650, 01 = 324, 10 = 161, 11 = 80.
- Each bus access lasts exactly one cycle with o_iocs=1. Every access is followed by one mandatory TURN cycle with o_iocs=0.
- FSM states: INIT_LO, INIT_HI, IDLE, RD, WR, TURN.
- INIT_LO: write DIV[7:0] to addr 10, latch the programmed br_cfg, then go to TURN.
- INIT_HI: write DIV[15:8] to addr 11, then go to TURN. o_busy falls on entry to IDLE.
- After reset, the sequence is INIT_LO, TURN, INIT_HI, TURN, IDLE. INIT_LO is entered on the first cycle after reset deassertion, once the synchroniser settles (2 cycles).
- IDLE priority, checked in order:
  - Reprogram request: go to INIT_LO and set o_busy=1.
  - i_rda=1: go to RD.
  - FIFO non-empty and i_tbr=1: go to WR.
  - Otherwise stay in IDLE.
- RD: drive o_iorw=1, o_ioaddr=00, and sample io_databus at the clock edge ending the cycle.
  - If the FIFO is not full, push the sampled byte.
  - If the FIFO is full, discard the byte and increment o_drop_cnt, holding at all-ones. The read still occurs so that SPART clears rda.
- WR: drive the FIFO head (transformed if UPPERCASE=1) onto io_databus with o_iorw=0, o_ioaddr=00, then pop the FIFO.
- TURN: one idle cycle, then return to IDLE. From a TURN that follows INIT_LO, go to INIT_HI instead.
- The interface contract with SPART: rda and tbr fall no later than the cycle after the access. TURN guarantees rda and tbr are never resampled stale.
- The FIFO is not flushed on reprogramming. Buffered characters are sent after the new divisor is written.
- br_cfg changing during INIT_HI completes the current sequence. The mismatch is then detected in IDLE and reprogramming restarts.
- A push and a pop cannot occur in the same cycle, because one access happens per cycle. o_fifo_level updates the cycle after RD or WR.
- Reset asserted mid-access: o_iocs drops and databus goes Z immediately (asynchronously). The FIFO empties, the counter clears, and init restarts.
- Status address 01 is never accessed by this block.

Decomposition:
- Package spart_drv_pkg holds:
  - ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH)
  - the FSM state enum
  - a function mapping br_cfg plus the parameters to the 16-bit divisor
  - the uppercase transform function
- Sub-module spart_drv_fifo: a synchronous FIFO parametrised by width and depth, with push, pop, full, empty and level outputs. Its head is read combinationally.

Test Plan:
- Reset, release with br_cfg=01 -> write 0x44 to addr 10, TURN, write 0x01 to addr 11; o_busy falls; no other accesses.
- UPPERCASE=1, rda pulse with databus=0x61, tbr=1 -> RD, TURN, WR driving 0x41 on addr 00; level goes 0, 1, 0. Input 0x5B is echoed unchanged.
- tbr held 0, 9 received bytes with FIFO_DEPTH=8 -> o_fifo_level=8, o_drop_cnt=1. Raising tbr then yields the first 8 bytes echoed in order.
- br_cfg switched 01 to 11 while the FIFO holds 2 bytes -> after 2 sync cycles, writes 0x50 to addr 10 and 0x00 to addr 11, then both bytes echo.
- rda=1 and tbr=1 with a non-empty FIFO in IDLE -> RD is performed first and WR only after TURN.
- rst_n asserted during a WR cycle -> o_iocs=0 and databus=Z in the same cycle. Level and drop count are 0, and the init sequence repeats after release.
